// File: rtl/dma_reg_sequencer.sv
// Hardware register-bus initiator for the iDMA 64-bit register frontend:
// programs one job, launches it via NEXT_ID, polls DONE, returns a completion record.
module dma_reg_sequencer #(
    parameter int unsigned AddrWidth    = 64,
    parameter int unsigned PollInterval = 16,
    parameter int unsigned PollTimeout  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 job_valid_i,
    output logic                 job_ready_o,
    input  logic [AddrWidth-1:0] job_src_i,
    input  logic [AddrWidth-1:0] job_dst_i,
    input  logic [AddrWidth-1:0] job_len_i,
    input  logic [2:0]           job_conf_i,
    output logic                 done_valid_o,
    input  logic                 done_ready_i,
    output logic [63:0]          done_id_o,
    output logic                 done_err_o,
    output logic                 done_timeout_o,
    output logic                 reg_valid_o,
    output logic                 reg_write_o,
    output logic [5:0]           reg_addr_o,
    output logic [63:0]          reg_wdata_o,
    output logic [7:0]           reg_wstrb_o,
    input  logic                 reg_ready_i,
    input  logic [63:0]          reg_rdata_i,
    input  logic                 reg_error_i,
    output logic                 busy_o
);

    localparam int unsigned WaitW = (PollInterval > 1) ? $clog2(PollInterval) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_SRC, S_WR_DST, S_WR_LEN, S_WR_CONF,
        S_RD_ID, S_WAIT, S_RD_DONE, S_RESP
    } state_e;

    state_e                 r_state, w_next;
    logic [AddrWidth-1:0]   r_src, r_dst, r_len;
    logic [2:0]             r_conf;
    logic [63:0]            r_id;
    logic                   r_err, r_to, r_job_ready;
    logic [31:0]            r_poll_cnt;
    logic [WaitW-1:0]       r_wait_cnt;

    logic                   w_acc, w_set_err, w_set_to, w_cap_id, w_poll_upd;
    logic [63:0]            w_diff;
    logic [31:0]            w_poll_inc;

    assign w_acc      = reg_valid_o && reg_ready_i;
    assign w_diff     = reg_rdata_i - r_id;
    assign w_poll_inc = (r_poll_cnt == '1) ? r_poll_cnt : r_poll_cnt + 32'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_set_err  = 1'b0;
        w_set_to   = 1'b0;
        w_cap_id   = 1'b0;
        w_poll_upd = 1'b0;
        unique case (r_state)
            S_IDLE:    if (job_ready_o && job_valid_i) w_next = S_WR_SRC;
            S_WR_SRC:  if (w_acc) begin
                           w_set_err = reg_error_i;
                           w_next    = reg_error_i ? S_RESP : S_WR_DST;
                       end
            S_WR_DST:  if (w_acc) begin
                           w_set_err = reg_error_i;
                           w_next    = reg_error_i ? S_RESP : S_WR_LEN;
                       end
            S_WR_LEN:  if (w_acc) begin
                           w_set_err = reg_error_i;
                           w_next    = reg_error_i ? S_RESP : S_WR_CONF;
                       end
            S_WR_CONF: if (w_acc) begin
                           w_set_err = reg_error_i;
                           w_next    = reg_error_i ? S_RESP : S_RD_ID;
                       end
            S_RD_ID:   if (w_acc) begin
                           w_cap_id = !reg_error_i;
                           if (reg_error_i || reg_rdata_i == '0) begin
                               w_set_err = 1'b1;
                               w_next    = S_RESP;
                           end else if (PollInterval == 0) begin
                               w_next = S_RD_DONE;
                           end else begin
                               w_next = S_WAIT;
                           end
                       end
            S_WAIT:    if (r_wait_cnt == WaitW'(PollInterval - 1)) w_next = S_RD_DONE;
            S_RD_DONE: if (w_acc) begin
                           // Wrap-safe completion: DONE has reached or passed our ID
                           if (reg_error_i) begin
                               w_set_err = 1'b1;
                               w_next    = S_RESP;
                           end else if (!w_diff[63]) begin
                               w_next = S_RESP;
                           end else begin
                               w_poll_upd = 1'b1;
                               if (PollTimeout != 0 && w_poll_inc >= 32'(PollTimeout)) begin
                                   w_set_to = 1'b1;
                                   w_next   = S_RESP;
                               end else if (PollInterval == 0) begin
                                   w_next = S_RD_DONE;
                               end else begin
                                   w_next = S_WAIT;
                               end
                           end
                       end
            S_RESP:    if (done_ready_i) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_conf      <= '0;
            r_id        <= '0;
            r_err       <= 1'b0;
            r_to        <= 1'b0;
            r_poll_cnt  <= '0;
            r_wait_cnt  <= '0;
            r_job_ready <= 1'b0;
        end else begin
            r_job_ready <= (w_next == S_IDLE);
            if (r_state == S_IDLE && w_next == S_WR_SRC) begin
                r_src      <= job_src_i;
                r_dst      <= job_dst_i;
                r_len      <= job_len_i;
                r_conf     <= job_conf_i;
                r_id       <= '0;
                r_err      <= 1'b0;
                r_to       <= 1'b0;
                r_poll_cnt <= '0;
                r_wait_cnt <= '0;
            end
            if (w_cap_id)   r_id       <= reg_rdata_i;
            if (w_set_err)  r_err      <= 1'b1;
            if (w_set_to)   r_to       <= 1'b1;
            if (w_poll_upd) r_poll_cnt <= w_poll_inc;
            if (r_state == S_WAIT)
                r_wait_cnt <= (w_next == S_RD_DONE) ? '0 : r_wait_cnt + 1'b1;
        end
    end

    always_comb begin
        reg_valid_o = 1'b0;
        reg_write_o = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        reg_wstrb_o = '0;
        unique case (r_state)
            S_WR_SRC:  begin
                           reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_wstrb_o = '1;
                           reg_addr_o  = 6'h00; reg_wdata_o = 64'(r_src);
                       end
            S_WR_DST:  begin
                           reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_wstrb_o = '1;
                           reg_addr_o  = 6'h08; reg_wdata_o = 64'(r_dst);
                       end
            S_WR_LEN:  begin
                           reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_wstrb_o = '1;
                           reg_addr_o  = 6'h10; reg_wdata_o = 64'(r_len);
                       end
            S_WR_CONF: begin
                           reg_valid_o = 1'b1; reg_write_o = 1'b1; reg_wstrb_o = '1;
                           reg_addr_o  = 6'h18; reg_wdata_o = {61'b0, r_conf};
                       end
            S_RD_ID:   begin reg_valid_o = 1'b1; reg_addr_o = 6'h28; end
            S_RD_DONE: begin reg_valid_o = 1'b1; reg_addr_o = 6'h30; end
            default:   ;
        endcase
    end

    assign job_ready_o    = r_job_ready;
    assign done_valid_o   = (r_state == S_RESP);
    assign done_id_o      = r_id;
    assign done_err_o     = r_err;
    assign done_timeout_o = r_to;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_dma_reg_sequencer.sv
// Directed self-checking bench for dma_reg_sequencer with a behavioural register slave.
module tb_dma_reg_sequencer;

    localparam int unsigned PI = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        job_valid_i, job_ready_o;
    logic [63:0] job_src_i, job_dst_i, job_len_i;
    logic [2:0]  job_conf_i;
    logic        done_valid_o, done_ready_i;
    logic [63:0] done_id_o;
    logic        done_err_o, done_timeout_o;
    logic        reg_valid_o, reg_write_o;
    logic [5:0]  reg_addr_o;
    logic [63:0] reg_wdata_o;
    logic [7:0]  reg_wstrb_o;
    logic        reg_ready_i;
    logic [63:0] reg_rdata_i;
    logic        reg_error_i;
    logic        busy_o;

    always #5 clk = ~clk;

    dma_reg_sequencer #(.AddrWidth(64), .PollInterval(PI), .PollTimeout(3)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_src_i(job_src_i), .job_dst_i(job_dst_i), .job_len_i(job_len_i),
        .job_conf_i(job_conf_i),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_id_o(done_id_o), .done_err_o(done_err_o), .done_timeout_o(done_timeout_o),
        .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
        .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [5:0]  addr;
        logic        wr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [31:0] cyc;
    } acc_t;

    int          n_total = 0;
    int          n_bad   = 0;
    acc_t        log_q[$];
    logic [63:0] done_q[$];
    logic [63:0] id_val, done_stuck;
    logic [5:0]  err_addr;
    bit          err_en, stall_en;
    logic [63:0] g_id;
    logic        g_err, g_to;
    int          g_dcyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_job(input logic [63:0] src, input logic [63:0] dst,
                           input logic [63:0] len, input logic [2:0] conf);
        int   cyc, stall, dv_cnt;
        bit   accepted, fin, pend;
        acc_t prev;
        log_q.delete();
        accepted = 0; fin = 0; pend = 0; cyc = 0; dv_cnt = 0;
        stall = stall_en ? int'($urandom_range(7, 0)) : 0;
        prev  = '0;
        @(negedge clk);
        job_valid_i = 1'b1; job_src_i = src; job_dst_i = dst; job_len_i = len; job_conf_i = conf;
        for (int n = 0; n < 3000 && !fin; n++) begin
            if (n > 0) @(negedge clk);
            reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0; done_ready_i = 1'b0;
            if (accepted) begin
                cyc++;
                job_valid_i = 1'b0;
            end else if (job_ready_o) begin
                accepted = 1;
            end
            if (pend) chk("valid_held", reg_valid_o, 1);
            if (reg_valid_o) begin
                if (pend) begin
                    chk("stable_addr", reg_addr_o, prev.addr);
                    chk("stable_wr", reg_write_o, prev.wr);
                    chk("stable_data", reg_wdata_o, prev.data);
                    chk("stable_strb", reg_wstrb_o, prev.strb);
                end
                if (stall > 0) begin
                    stall--;
                    pend = 1;
                    prev = '{addr: reg_addr_o, wr: reg_write_o, data: reg_wdata_o,
                             strb: reg_wstrb_o, cyc: 32'(cyc)};
                end else begin
                    pend = 0;
                    reg_ready_i = 1'b1;
                    if (reg_addr_o == 6'h28) reg_rdata_i = id_val;
                    else if (reg_addr_o == 6'h30)
                        reg_rdata_i = (done_q.size() > 0) ? done_q.pop_front() : done_stuck;
                    if (err_en && reg_addr_o == err_addr) reg_error_i = 1'b1;
                    log_q.push_back('{addr: reg_addr_o, wr: reg_write_o, data: reg_wdata_o,
                                      strb: reg_wstrb_o, cyc: 32'(cyc)});
                    stall = stall_en ? int'($urandom_range(7, 0)) : 0;
                end
            end
            if (done_valid_o) begin
                if (dv_cnt == 0) begin
                    g_dcyc = cyc;
                    chk("ready_in_resp", job_ready_o, 0);
                end
                dv_cnt++;
                if (dv_cnt >= 2) begin
                    done_ready_i = 1'b1;
                    g_id = done_id_o; g_err = done_err_o; g_to = done_timeout_o;
                    fin = 1;
                end
            end
            @(posedge clk);
        end
        if (!fin) chk("job_budget", 0, 1);
        @(negedge clk);
        done_ready_i = 1'b0; reg_ready_i = 1'b0; reg_error_i = 1'b0; job_valid_i = 1'b0;
        chk("ready_after_resp", job_ready_o, 1);
        chk("idle_after_resp", busy_o, 0);
    endtask

    task automatic check_seq(input logic [63:0] src, input logic [63:0] dst,
                             input logic [63:0] len, input logic [2:0] conf,
                             input int n_done, input bit chk_cyc);
        logic [5:0]  ea[5];
        logic [63:0] ed[4];
        ea = '{6'h00, 6'h08, 6'h10, 6'h18, 6'h28};
        ed = '{src, dst, len, {61'b0, conf}};
        chk("n_access", log_q.size(), 64'(5 + n_done));
        for (int i = 0; i < log_q.size() && i < 5 + n_done; i++) begin
            if (i < 4) begin
                chk($sformatf("addr%0d", i), log_q[i].addr, ea[i]);
                chk($sformatf("wr%0d", i), log_q[i].wr, 1);
                chk($sformatf("data%0d", i), log_q[i].data, ed[i]);
                chk($sformatf("strb%0d", i), log_q[i].strb, 8'hFF);
            end else begin
                chk($sformatf("addr%0d", i), log_q[i].addr, (i == 4) ? 6'h28 : 6'h30);
                chk($sformatf("wr%0d", i), log_q[i].wr, 0);
            end
            if (chk_cyc)
                chk($sformatf("cyc%0d", i), log_q[i].cyc,
                    (i < 5) ? 64'(i + 1) : 64'(6 + PI + (i - 5) * (PI + 1)));
        end
    endtask

    initial begin
        bit found;
        rst_i = 1'b1; job_valid_i = 0; job_src_i = '0; job_dst_i = '0; job_len_i = '0;
        job_conf_i = '0; done_ready_i = 0; reg_ready_i = 0; reg_rdata_i = '0; reg_error_i = 0;
        err_en = 0; stall_en = 0; err_addr = '0; id_val = '0; done_stuck = '0;
        #22;
        chk("rst_job_ready", job_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_reg_valid", reg_valid_o, 0);
        chk("rst_done_valid", done_valid_o, 0);
        @(negedge clk); rst_i = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("post_rst_job_ready", job_ready_o, 1);

        // Nominal: exact bus sequence and cycle schedule
        id_val = 64'd5; done_q = '{64'd4, 64'd5};
        run_job(64'h8000_0000, 64'h8001_0000, 64'h40, 3'b001);
        check_seq(64'h8000_0000, 64'h8001_0000, 64'h40, 3'b001, 2, 1);
        chk("nom_done_cyc", g_dcyc, 12);
        chk("nom_id", g_id, 64'd5);
        chk("nom_err", g_err, 0);
        chk("nom_to", g_to, 0);

        // Random slave stalls
        stall_en = 1; id_val = 64'd5; done_q = '{64'd4, 64'd5};
        run_job(64'h8000_0000, 64'h8001_0000, 64'h40, 3'b110);
        check_seq(64'h8000_0000, 64'h8001_0000, 64'h40, 3'b110, 2, 0);
        chk("stall_id", g_id, 64'd5);
        chk("stall_err", g_err, 0);
        chk("stall_to", g_to, 0);
        stall_en = 0;

        // ID wrap
        id_val = 64'd1; done_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
        run_job(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 64'h1000, 3'b010);
        check_seq(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210, 64'h1000, 3'b010, 2, 1);
        chk("wrap_id", g_id, 64'd1);
        chk("wrap_err", g_err, 0);

        // Zero ID from NEXT_ID
        id_val = 64'd0; done_q.delete();
        run_job(64'h10, 64'h20, 64'h30, 3'b000);
        check_seq(64'h10, 64'h20, 64'h30, 3'b000, 0, 1);
        chk("zid_err", g_err, 1);
        chk("zid_id", g_id, 0);

        // Bus error on DST write
        err_en = 1; err_addr = 6'h08; id_val = 64'd9;
        run_job(64'hA0, 64'hB0, 64'hC0, 3'b001);
        chk("berr_n_access", log_q.size(), 2);
        if (log_q.size() >= 2) chk("berr_last_addr", log_q[1].addr, 6'h08);
        chk("berr_err", g_err, 1);
        chk("berr_id", g_id, 0);
        chk("berr_to", g_to, 0);
        err_en = 0;

        // Poll timeout
        id_val = 64'd10; done_q.delete(); done_stuck = 64'd9;
        run_job(64'h100, 64'h200, 64'h300, 3'b100);
        check_seq(64'h100, 64'h200, 64'h300, 3'b100, 3, 1);
        chk("to_timeout", g_to, 1);
        chk("to_err", g_err, 0);
        chk("to_id", g_id, 64'd10);

        // Asynchronous reset while a DONE read is pending
        id_val = 64'd7; found = 0;
        @(negedge clk);
        job_valid_i = 1'b1; job_src_i = 64'h55; job_dst_i = 64'h66; job_len_i = 64'h77;
        job_conf_i = 3'b011;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            reg_ready_i = 1'b0;
            if (busy_o) job_valid_i = 1'b0;
            if (reg_valid_o && reg_addr_o == 6'h30) found = 1;
            else begin
                reg_ready_i = reg_valid_o;
                reg_rdata_i = id_val;
            end
        end
        chk("rst_reached_done", found, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_reg_valid", reg_valid_o, 0);
        chk("arst_reg_addr", reg_addr_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_job_ready", job_ready_o, 0);
        chk("arst_done_valid", done_valid_o, 0);
        chk("arst_done_id", done_id_o, 0);
        @(negedge clk); @(negedge clk); rst_i = 1'b0;
        @(negedge clk);
        id_val = 64'd5; done_q = '{64'd4, 64'd5};
        run_job(64'h8000_0000, 64'h8001_0000, 64'h40, 3'b001);
        check_seq(64'h8000_0000, 64'h8001_0000, 64'h40, 3'b001, 2, 1);
        chk("post_arst_id", g_id, 64'd5);
        chk("post_arst_err", g_err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
